cipher_round_key_seq: RTL and testbench
=======================================

Name: cipher_round_key_seq

Overview:
- Upstream stage of the cipher unit's 15:1 round-word selector.
- Buffers up to 15 32-bit round-key words, loaded sequentially over a valid/ready handshake.
- Presents all stored words in parallel (RK0..RK14) as the selector's data inputs.
- Generates the 4-bit round index S15 that drives the selector's select input, advancing one round per datapath acknowledge.

Parameters:
- NR, 14, final round index. Legal values are 10, 12 and 14 (AES-128/192/256). Number of words loaded is NR+1. Any other value is an elaboration error.

Ports:
- CLK  input  1  clock, rising-edge active
- RST  input  1  asynchronous, active-high reset
- CLEAR  input  1  synchronous flush back to key loading
- KEY_VALID  input  1  KEY_WORD is valid
- KEY_WORD  input  32  round-key word, written in index order 0..NR
- KEY_READY  output  1  block accepts a key word
- LOADED  output  1  all NR+1 words are stored
- START  input  1  single-cycle request to begin a round sequence
- ROUND_ADV  input  1  datapath has finished the current round
- BUSY  output  1  round sequence in progress
- DONE  output  1  single-cycle pulse: final round acknowledged
- S15  output  4  current round index, to the selector's select input
- RK0..RK14  output  32 each  stored round-key words, to selector inputs IN0..IN14

Behaviour:
- Reset (async, RST=1):
  - State = IDLE; write pointer WP = 0; S15 = 0.
  - RK0..RK14 = 0; KEY_READY = 1; LOADED = BUSY = DONE = 0.
- Priority: RST > CLEAR > all other inputs.
- States: IDLE (loading), LOADED, RUN. All outputs are registered or decoded from state; there are no combinational input-to-output paths.
- IDLE:
  - KEY_READY = 1.
  - On KEY_VALID & KEY_READY: RK[WP] <= KEY_WORD, WP <= WP+1. The word is visible on RK[WP] the cycle after the accepting edge.
  - When the accepted word has WP == NR: next state LOADED, KEY_READY deasserts the following cycle. Exactly NR+1 handshakes complete a load.
  - START in IDLE is ignored. No sequence may begin before LOADED = 1.
- LOADED:
  - LOADED = 1, KEY_READY = 0, S15 = 0. KEY_VALID is ignored.
  - START: next state RUN, BUSY = 1 from the next cycle, S15 stays 0.
- RUN:
  - BUSY = 1, LOADED = 1.
  - ROUND_ADV with S15 < NR: S15 <= S15+1 at that edge.
  - ROUND_ADV with S15 == NR: DONE = 1 for exactly the next cycle, S15 <= 0, state <= LOADED, BUSY = 0 the next cycle.
  - START during RUN is ignored.
  - Simultaneous START and final ROUND_ADV: the sequence ends, DONE pulses, and START is not queued.
- ROUND_ADV outside RUN is ignored.
- S15 never exceeds NR. Values 15 and above never occur.
- RK slots with index > NR stay 0 from reset and are never written.
- CLEAR (any state):
  - Next state IDLE, WP = 0, S15 = 0, BUSY = 0, LOADED = 0, KEY_READY = 1.
  - No DONE pulse is produced.
  - RK registers retain their contents until overwritten by a new load.
- RST asserted mid-load or mid-run returns everything to reset values immediately, with no dependence on the clock.

Test Plan:
- Reset then NR=14 load of words 32'h1000_0000+i (i=0..14), KEY_VALID held high -> 15 accepts in 15 cycles, RK14 = 32'h1000_000E, LOADED = 1, KEY_READY = 0 on cycle 16.
- Backpressure/gaps: KEY_VALID toggled every other cycle during load -> only valid cycles write. RK5 = 6th valid word. A 16th word offered after LOADED is not captured.
- Full run: START, then 14 ROUND_ADV pulses -> S15 steps 0→14. The 15th ROUND_ADV gives DONE high for 1 cycle, S15 = 0, BUSY = 0, LOADED = 1.
- Illegal/ignored inputs: START during load at WP = 7 -> no BUSY. ROUND_ADV in LOADED -> S15 stays 0. START at S15 = 5 in RUN -> S15 is unaffected.
- NR=10 instance: 11 words load, 11th ROUND_ADV gives DONE. RK11..RK14 remain 32'h0. S15 maximum is 10.
- Mid-operation flush: CLEAR at S15 = 6 -> next cycle IDLE, KEY_READY = 1, S15 = 0, no DONE. Async RST pulse mid-load at WP = 3 -> all outputs at reset values before the next CLK edge, RK0 = 0.

Source files
------------

// File: rtl/cipher_round_key_seq_if.sv
// Round-key load handshake, run control and parallel round-key/select outputs.
// Master drives the load and run controls; slave is the key sequencer.
interface cipher_round_key_seq_if;
    logic        CLEAR;
    logic        KEY_VALID;
    logic [31:0] KEY_WORD;
    logic        KEY_READY;
    logic        LOADED;
    logic        START;
    logic        ROUND_ADV;
    logic        BUSY;
    logic        DONE;
    logic [3:0]  S15;
    logic [31:0] RK [0:14];

    modport master (
        output CLEAR, KEY_VALID, KEY_WORD, START, ROUND_ADV,
        input  KEY_READY, LOADED, BUSY, DONE, S15, RK
    );

    modport slave (
        input  CLEAR, KEY_VALID, KEY_WORD, START, ROUND_ADV,
        output KEY_READY, LOADED, BUSY, DONE, S15, RK
    );
endinterface

// File: rtl/cipher_round_key_seq.sv
// Stores NR+1 round-key words and steps the 15:1 selector index, one round per ROUND_ADV.
// Every output is registered or state-decoded; KEY_READY is low once the load completes.
module cipher_round_key_seq #(
    parameter int NR = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    cipher_round_key_seq_if.slave bus
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("cipher_round_key_seq: NR must be 10, 12 or 14, got %0d", NR);
    end

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADED,
        ST_RUN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wp_q, wp_d;
    logic [3:0] s15_q, s15_d;
    logic       done_q, done_d;
    logic       key_wr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wp_q    <= '0;
            s15_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            s15_q   <= s15_d;
            done_q  <= done_d;
        end
    end

    // CLEAR overrides everything and never produces DONE; RK contents are kept.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        s15_d   = s15_q;
        done_d  = 1'b0;
        key_wr  = 1'b0;
        if (bus.CLEAR) begin
            state_d = ST_IDLE;
            wp_d    = '0;
            s15_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.KEY_VALID) begin
                        key_wr = 1'b1;
                        if (wp_q == LAST) begin
                            state_d = ST_LOADED;
                            wp_d    = '0;
                        end else begin
                            wp_d = wp_q + 4'd1;
                        end
                    end
                end
                ST_LOADED: begin
                    s15_d = '0;
                    if (bus.START) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.ROUND_ADV) begin
                        if (s15_q == LAST) begin
                            done_d  = 1'b1;
                            s15_d   = '0;
                            state_d = ST_LOADED;
                        end else begin
                            s15_d = s15_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wp_d    = '0;
                    s15_d   = '0;
                end
            endcase
        end
    end

    assign bus.KEY_READY = (state_q == ST_IDLE);
    assign bus.LOADED    = (state_q != ST_IDLE);
    assign bus.BUSY      = (state_q == ST_RUN);
    assign bus.DONE      = done_q;
    assign bus.S15       = s15_q;

    // Slots above NR have no storage at all and read as zero forever.
    for (genvar i = 0; i < 15; i++) begin : g_rk
        if (i <= NR) begin : g_used
            logic [31:0] rk_q;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    rk_q <= '0;
                end else if (key_wr && (wp_q == 4'(i))) begin
                    rk_q <= bus.KEY_WORD;
                end
            end
            assign bus.RK[i] = rk_q;
        end else begin : g_unused
            assign bus.RK[i] = '0;
        end
    end

    a_s15_range : assert property (@(posedge CLK) disable iff (RST) s15_q <= LAST);
    a_wp_range  : assert property (@(posedge CLK) disable iff (RST) wp_q <= LAST);
    a_done_once : assert property (@(posedge CLK) disable iff (RST) done_q |=> !done_q);

endmodule

// File: tb/tb_cipher_round_key_seq.sv
// Bench for cipher_round_key_seq: NR=14 and NR=10 instances share stimulus, each tracked by its own model.
module tb_cipher_round_key_seq;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic        clear, kv, start, adv;
    logic [31:0] kw;

    cipher_round_key_seq_if if14 ();
    cipher_round_key_seq_if if10 ();

    assign if14.CLEAR     = clear;
    assign if14.KEY_VALID = kv;
    assign if14.KEY_WORD  = kw;
    assign if14.START     = start;
    assign if14.ROUND_ADV = adv;
    assign if10.CLEAR     = clear;
    assign if10.KEY_VALID = kv;
    assign if10.KEY_WORD  = kw;
    assign if10.START     = start;
    assign if10.ROUND_ADV = adv;

    cipher_round_key_seq #(.NR(14)) u_dut14 (.CLK(CLK), .RST(RST), .bus(if14.slave));
    cipher_round_key_seq #(.NR(10)) u_dut10 (.CLK(CLK), .RST(RST), .bus(if10.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 = loading, 1 = loaded, 2 = running.
    int          nr_of [2] = '{14, 10};
    int          m_phase [2];
    int          m_wp [2];
    int          m_rnd [2];
    bit          m_done [2];
    logic [31:0] m_rk [2][15];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_wp[k]    = 0;
            m_rnd[k]   = 0;
            m_done[k]  = 0;
            for (int j = 0; j < 15; j++) m_rk[k][j] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            if (clear) begin
                m_phase[k] = 0;
                m_wp[k]    = 0;
                m_rnd[k]   = 0;
            end else if (m_phase[k] == 0) begin
                if (kv) begin
                    m_rk[k][m_wp[k]] = kw;
                    if (m_wp[k] == nr_of[k]) begin
                        m_phase[k] = 1;
                        m_wp[k]    = 0;
                    end else begin
                        m_wp[k] = m_wp[k] + 1;
                    end
                end
            end else if (m_phase[k] == 1) begin
                if (start) m_phase[k] = 2;
            end else if (adv) begin
                if (m_rnd[k] == nr_of[k]) begin
                    m_done[k]  = 1;
                    m_rnd[k]   = 0;
                    m_phase[k] = 1;
                end else begin
                    m_rnd[k] = m_rnd[k] + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] r [15];
        logic        rdy, ld, bsy, dn;
        logic [3:0]  s;
        string       p;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                rdy = if14.KEY_READY; ld = if14.LOADED; bsy = if14.BUSY; dn = if14.DONE; s = if14.S15;
                for (int j = 0; j < 15; j++) r[j] = if14.RK[j];
            end else begin
                rdy = if10.KEY_READY; ld = if10.LOADED; bsy = if10.BUSY; dn = if10.DONE; s = if10.S15;
                for (int j = 0; j < 15; j++) r[j] = if10.RK[j];
            end
            p = $sformatf("nr%0d", nr_of[k]);
            check({p, ".KEY_READY"}, 32'(rdy), 32'(m_phase[k] == 0));
            check({p, ".LOADED"},    32'(ld),  32'(m_phase[k] != 0));
            check({p, ".BUSY"},      32'(bsy), 32'(m_phase[k] == 2));
            check({p, ".DONE"},      32'(dn),  32'(m_done[k]));
            check({p, ".S15"},       32'(s),   32'(m_rnd[k]));
            check({p, ".S15_le_NR"}, 32'(int'(s) <= nr_of[k]), 32'd1);
            for (int j = 0; j < 15; j++)
                check($sformatf("%s.RK%0d", p, j), r[j], m_rk[k][j]);
        end
    endtask

    // Inputs are set after a falling edge; one call = one rising edge plus full compare.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    typedef struct {
        logic        clr, kv;
        logic [31:0] kw;
        logic        st, adv;
        logic        rdy, ld, busy, done;
        logic [3:0]  s15;
        logic        done10;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] words [15];

    initial begin
        RST = 1'b1;
        {clear, kv, start, adv} = '0;
        kw = '0;
        model_reset();

        // Directed NR=14 load / run table; expectations describe the NR=14 instance after the edge.
        for (int i = 0; i < 15; i++)
            tbl.push_back('{1'b0, 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0,
                            i != 14, i == 14, 1'b0, 1'b0, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0});
        for (int r = 1; r <= 5; r++)
            tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'(r), 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0});
        for (int r = 6; r <= 14; r++)
            tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'(r), r == 11});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});

        @(negedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
        RST = 1'b0;

        foreach (tbl[i]) begin
            clear = tbl[i].clr; kv = tbl[i].kv; kw = tbl[i].kw;
            start = tbl[i].st;  adv = tbl[i].adv;
            cycle();
            check($sformatf("tbl%0d.KEY_READY", i), 32'(if14.KEY_READY), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d.LOADED", i),    32'(if14.LOADED),    32'(tbl[i].ld));
            check($sformatf("tbl%0d.BUSY", i),      32'(if14.BUSY),      32'(tbl[i].busy));
            check($sformatf("tbl%0d.DONE", i),      32'(if14.DONE),      32'(tbl[i].done));
            check($sformatf("tbl%0d.S15", i),       32'(if14.S15),       32'(tbl[i].s15));
            check($sformatf("tbl%0d.DONE_nr10", i), 32'(if10.DONE),      32'(tbl[i].done10));
        end
        {clear, kv, start, adv} = '0;
        check("nr14.RK14_loaded", if14.RK[14], 32'h1000_000E);
        check("nr10.RK10_loaded", if10.RK[10], 32'h1000_000A);
        for (int j = 11; j < 15; j++)
            check($sformatf("nr10.RK%0d_zero", j), if10.RK[j], 32'h0);

        // Flush, then reload with KEY_VALID every other cycle and a START at WP=7.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int j = 0; j < 15; j++) words[j] = $urandom;
        begin
            int acc = 0;
            int c   = 0;
            while (acc < 15 && c < 100) begin
                kv    = (c % 2 == 0);
                kw    = kv ? words[acc] : $urandom;
                start = (acc == 7) && !kv;
                cycle();
                if (start) check("start_during_load.BUSY", 32'(if14.BUSY), 32'd0);
                if (kv) acc++;
                c++;
            end
            check("gap_load_accepts", 32'(acc), 32'd15);
        end
        start = 1'b0;
        check("gap_load.LOADED", 32'(if14.LOADED), 32'd1);
        check("gap_load.RK5", if14.RK[5], words[5]);
        kv = 1'b1;
        kw = ~words[0];
        cycle();
        kv = 1'b0;
        check("extra_word.RK0", if14.RK[0], words[0]);

        // Run to S15=6, then flush mid-sequence.
        start = 1'b1;
        cycle();
        start = 1'b0;
        adv   = 1'b1;
        repeat (6) cycle();
        adv = 1'b0;
        check("pre_clear.S15", 32'(if14.S15), 32'd6);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("clear.KEY_READY", 32'(if14.KEY_READY), 32'd1);
        check("clear.S15",       32'(if14.S15),       32'd0);
        check("clear.DONE",      32'(if14.DONE),      32'd0);
        check("clear.BUSY",      32'(if14.BUSY),      32'd0);
        check("clear.RK3_kept",  if14.RK[3],          words[3]);

        // Three words loaded, then an asynchronous reset between clock edges.
        kv = 1'b1;
        for (int j = 0; j < 3; j++) begin
            kw = 32'hA5A5_0000 + 32'(j);
            cycle();
        end
        kv = 1'b0;
        #2 RST = 1'b1;
        #1;
        model_reset();
        check("async_rst.KEY_READY", 32'(if14.KEY_READY), 32'd1);
        check("async_rst.LOADED",    32'(if14.LOADED),    32'd0);
        check("async_rst.RK0",       if14.RK[0],          32'h0);
        compare_all();
        #1 RST = 1'b0;
        @(negedge CLK);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            clear = ($urandom_range(0, 99) < 2);
            kv    = ($urandom_range(0, 99) < 60);
            kw    = $urandom;
            start = ($urandom_range(0, 99) < 20);
            adv   = ($urandom_range(0, 99) < 50);
            cycle();
        end
        {clear, kv, start, adv} = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
